// File: rtl/rv32i_defs.sv
// Shared RV32I datapath definitions: ALU opcode encoding and ALU status layout.
package rv32i_defs;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        ALU_SUM = 3'b000,
        ALU_SUB = 3'b001,
        ALU_OR  = 3'b010,
        ALU_AND = 3'b011,
        ALU_SLT = 3'b100
    } alu_opcode;

    localparam int ALU_STATUS_W = 4;
    localparam int ST_N = 3;
    localparam int ST_Z = 2;
    localparam int ST_C = 1;
    localparam int ST_V = 0;

    localparam logic [ALU_STATUS_W-1:0] ALU_STATUS_UNDEF = 4'b0100;

endpackage

// File: rtl/alu_share_arbiter_rr_picker.sv
// Rotating-priority picker: first asserted request at or above i_ptr, wrapping
// to index 0. Produces a one-hot grant and the matching binary index.
module rr_picker #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_any   = 1'b0;
        // Upper segment [ptr .. NUM_REQ-1] first, then the wrapped segment [0 .. ptr-1].
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[i] && (i >= int'(i_ptr))) begin
                o_grant[i] = 1'b1;
                o_idx      = ID_W'(i);
                o_any      = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!o_any && i_req[i] && (i < int'(i_ptr))) begin
                o_grant[i] = 1'b1;
                o_idx      = ID_W'(i);
                o_any      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// One ALU shared by NUM_REQ requesters through a round-robin arbiter and a
// one-entry response register. Define ALU_ARB_FIXED_PRIO_EN for fixed priority (req 0 highest).
module alu_share_arbiter
    import rv32i_defs::*;
#(
    parameter int N       = 32,
    parameter int NUM_REQ = 3,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*N-1:0]          req_a,
    input  logic [NUM_REQ*N-1:0]          req_b,
    input  logic [NUM_REQ*ALU_OP_W-1:0]   req_op,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [N-1:0]                  resp_result,
    output logic [ALU_STATUS_W-1:0]       resp_status,
    output logic [ID_W-1:0]               resp_id
);

    logic [NUM_REQ-1:0]      r_valid;
    logic [N-1:0]            r_result;
    logic [ALU_STATUS_W-1:0] r_status;
    logic [ID_W-1:0]         r_id;

    logic [ID_W-1:0]         w_ptr;
    logic [NUM_REQ-1:0]      w_grant;
    logic [ID_W-1:0]         w_idx;
    logic                    w_any;
    logic                    w_drain;
    logic                    w_out_free;
    logic                    w_xfer;

    logic [N-1:0]            w_a;
    logic [N-1:0]            w_b;
    logic [ALU_OP_W-1:0]     w_op;
    logic [N:0]              w_sum;
    logic [N:0]              w_diff;
    logic [N-1:0]            w_res;
    logic                    w_c;
    logic                    w_v;
    logic                    w_def;
    logic [ALU_STATUS_W-1:0] w_status;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_picker (
        .i_req   (req_valid),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    // r_valid is one-hot at r_id, so this equals resp_ready[resp_id] when valid.
    assign w_drain    = |(r_valid & resp_ready);
    assign w_out_free = ~(|r_valid) | w_drain;
    assign req_ready  = (rst_n && w_out_free) ? w_grant : '0;
    assign w_xfer     = w_any && w_out_free && rst_n;

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [ID_W-1:0] r_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
        end
    end

    assign w_ptr = r_ptr;
`endif

    // Idle cycles fall through to requester 0; the ALU output is then unused.
    always_comb begin
        w_a  = req_a[N-1:0];
        w_b  = req_b[N-1:0];
        w_op = req_op[ALU_OP_W-1:0];
        for (int i = 1; i < NUM_REQ; i++) begin
            if (w_idx == ID_W'(i)) begin
                w_a  = req_a[i*N +: N];
                w_b  = req_b[i*N +: N];
                w_op = req_op[i*ALU_OP_W +: ALU_OP_W];
            end
        end
    end

    assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
    assign w_diff = {1'b0, w_a} - {1'b0, w_b};

    // C is carry-out for SUM and borrow for SUB; logic ops and SLT clear C/V.
    always_comb begin
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        w_def = 1'b1;
        case (w_op)
            ALU_SUM: begin
                w_res = w_sum[N-1:0];
                w_c   = w_sum[N];
                w_v   = (w_a[N-1] == w_b[N-1]) && (w_sum[N-1] != w_a[N-1]);
            end
            ALU_SUB: begin
                w_res = w_diff[N-1:0];
                w_c   = w_diff[N];
                w_v   = (w_a[N-1] != w_b[N-1]) && (w_diff[N-1] != w_a[N-1]);
            end
            ALU_OR:  w_res = w_a | w_b;
            ALU_AND: w_res = w_a & w_b;
            ALU_SLT: w_res = {{(N-1){1'b0}}, ($signed(w_a) < $signed(w_b))};
            default: w_def = 1'b0;
        endcase
    end

    always_comb begin
        w_status = ALU_STATUS_UNDEF;
        if (w_def) begin
            w_status[ST_N] = w_res[N-1];
            w_status[ST_Z] = (w_res == '0);
            w_status[ST_C] = w_c;
            w_status[ST_V] = w_v;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_result <= '0;
            r_status <= '0;
            r_id     <= '0;
        end else if (w_xfer) begin
            r_valid  <= w_grant;
            r_result <= w_res;
            r_status <= w_status;
            r_id     <= w_idx;
        end else if (w_drain) begin
            r_valid  <= '0;
        end
    end

    assign resp_valid  = r_valid;
    assign resp_result = r_result;
    assign resp_status = r_status;
    assign resp_id     = r_id;

    a_onehot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(req_ready) && $onehot0(resp_valid));

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: expected responses queued at issue time,
// a negedge monitor pops and compares each accepted response.
module tb_alu_share_arbiter;
    import rv32i_defs::*;

    localparam int N       = 32;
    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;
    localparam int W       = NUM_REQ + N + 4 + ID_W;

    logic                        clk;
    logic                        rst_n;
    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ*N-1:0]        req_a;
    logic [NUM_REQ*N-1:0]        req_b;
    logic [NUM_REQ*ALU_OP_W-1:0] req_op;
    logic [NUM_REQ-1:0]          resp_valid;
    logic [NUM_REQ-1:0]          resp_ready;
    logic [N-1:0]                resp_result;
    logic [3:0]                  resp_status;
    logic [ID_W-1:0]             resp_id;

    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    alu_share_arbiter #(.N(N), .NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_result (resp_result),
        .resp_status (resp_status),
        .resp_id     (resp_id)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        req_a[r*N +: N]               = a;
        req_b[r*N +: N]               = b;
        req_op[r*ALU_OP_W +: ALU_OP_W] = op;
    endtask

    task automatic push_exp(input logic [2:0] v, input logic [31:0] r, input logic [3:0] s, input logic [1:0] id);
        exp_q.push_back({v, r, s, id});
    endtask

    // Scoreboard monitor: a response is consumed when valid meets ready at the next edge
    always @(negedge clk) begin
        if (rst_n && |(resp_valid & resp_ready)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL resp_unexpected: got id %0d result %h, expected no response", resp_id, resp_result);
            end else begin
                check("resp", {resp_valid, resp_result, resp_status, resp_id}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        n_checks++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    logic [2:0] g_seq [5];

    initial begin
        g_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010};
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = '1;
        req_valid  = 3'b111;
        #12;
        check("rst_req_ready", req_ready, 3'b000);
        check("rst_resp_valid", resp_valid, 3'b000);
        check("rst_result", resp_result, 32'h0);
        check("rst_status", resp_status, 4'h0);
        check("rst_id", resp_id, 2'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Req0 SUM 5+7
        push_exp(3'b001, 32'd12, 4'b0000, 2'd0);
        set_req(0, ALU_SUM, 32'd5, 32'd7);
        req_valid = 3'b001;
        @(negedge clk); check("t1_grant", req_ready, 3'b001);
        tick(); req_valid = '0;
        @(negedge clk); check("t1_latency", resp_valid, 3'b001);
        tick();

        // Req1 SUB with borrow, req2 SUM with signed overflow
        push_exp(3'b010, 32'hFFFF_FFFE, 4'b1010, 2'd1);
        push_exp(3'b100, 32'h8000_0000, 4'b1001, 2'd2);
        set_req(1, ALU_SUB, 32'd3, 32'd5);
        set_req(2, ALU_SUM, 32'h7FFF_FFFF, 32'd1);
        req_valid = 3'b110;
        @(negedge clk); check("t2_grant_a", req_ready, 3'b010);
        tick(); req_valid = 3'b100;
        @(negedge clk); check("t2_grant_b", req_ready, 3'b100);
        tick(); req_valid = '0;
        tick();

        // All three continuously valid: rotation 0,1,2,0,1
        set_req(0, ALU_SUB, 32'd5, 32'd5);
        set_req(1, ALU_AND, 32'h0000_FF00, 32'h0000_0FF0);
        set_req(2, ALU_SLT, 32'hFFFF_FFFF, 32'd1);
        push_exp(3'b001, 32'h0, 4'b0100, 2'd0);
        push_exp(3'b010, 32'h0000_0F00, 4'b0000, 2'd1);
        push_exp(3'b100, 32'h1, 4'b0000, 2'd2);
        push_exp(3'b001, 32'h0, 4'b0100, 2'd0);
        push_exp(3'b010, 32'h0000_0F00, 4'b0000, 2'd1);
        req_valid = 3'b111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); check($sformatf("t3_grant%0d", k), req_ready, g_seq[k]);
            tick();
        end
        req_valid = '0;
        tick();

        // Backpressure for 3 cycles, then same-cycle drain and refill
        resp_ready = 3'b000;
        set_req(2, ALU_SUM, 32'd10, 32'd20);
        set_req(0, ALU_SUM, 32'd1, 32'd2);
        push_exp(3'b100, 32'd30, 4'b0000, 2'd2);
        push_exp(3'b001, 32'd3, 4'b0000, 2'd0);
        req_valid = 3'b101;
        @(negedge clk); check("t4_grant", req_ready, 3'b100);
        tick(); req_valid = 3'b001;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("t4_stall_ready%0d", k), req_ready, 3'b000);
            check($sformatf("t4_hold_valid%0d", k), resp_valid, 3'b100);
            check($sformatf("t4_hold_result%0d", k), resp_result, 32'd30);
            check($sformatf("t4_hold_status%0d", k), resp_status, 4'b0000);
            check($sformatf("t4_hold_id%0d", k), resp_id, 2'd2);
            tick();
        end
        resp_ready = 3'b111;
        @(negedge clk); check("t4_refill", req_ready, 3'b001);
        tick(); req_valid = '0;
        tick();

        // Undefined opcode from req2
        push_exp(3'b100, 32'h0, 4'b0100, 2'd2);
        set_req(2, 3'b111, 32'd123, 32'd456);
        req_valid = 3'b100;
        @(negedge clk); check("t5_grant", req_ready, 3'b100);
        tick(); req_valid = '0;
        @(negedge clk);
        check("t5_no_x", $isunknown({resp_valid, resp_result, resp_status, resp_id, req_ready}), 1'b0);
        tick();

        // Reset while a response is pending and the pointer sits at 2
        resp_ready = 3'b000;
        set_req(1, ALU_SUM, 32'd9, 32'd9);
        req_valid = 3'b010;
        @(negedge clk); check("t6_grant", req_ready, 3'b010);
        tick(); req_valid = '0;
        @(negedge clk);
        check("t6_pre_valid", resp_valid, 3'b010);
        check("t6_pre_result", resp_result, 32'd18);
        #2;
        rst_n = 1'b0;
        set_req(0, ALU_SUM, 32'd4, 32'd4);
        req_valid = 3'b111;
        #1;
        check("t6_rst_valid", resp_valid, 3'b000);
        check("t6_rst_result", resp_result, 32'h0);
        check("t6_rst_status", resp_status, 4'h0);
        check("t6_rst_id", resp_id, 2'd0);
        check("t6_rst_ready", req_ready, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        resp_ready = 3'b111;
        push_exp(3'b001, 32'd8, 4'b0000, 2'd0);
        #1;
        check("t6_first_grant", req_ready, 3'b001);
        tick(); req_valid = '0;
        tick();
        tick();

        check("q_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
